// File: rtl/tlb_pkg.sv
// tlb_pkg: shared types and default sizing for the ASID-tagged TLB.
//
// Contents:
//   - DEF_* width constants (the default build of asid_tlb)
//   - tlb_state_e : walker handshake FSM states (IDLE, WAIT)
//   - tlb_entry_t : one translation entry at the default widths
//   - idx_width() : index width for an entry count (at least 1 bit)
package tlb_pkg;

  localparam int DEF_VA_WIDTH          = 32;
  localparam int DEF_PAGE_OFFSET_WIDTH = 12;
  localparam int DEF_PPN_WIDTH         = 20;
  localparam int DEF_NUM_ENTRIES       = 16;
  localparam int DEF_ASID_WIDTH        = 8;
  localparam int DEF_VPN_WIDTH         = DEF_VA_WIDTH - DEF_PAGE_OFFSET_WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } tlb_state_e;

  typedef struct packed {
    logic [DEF_VPN_WIDTH-1:0]  vpn;
    logic [DEF_ASID_WIDTH-1:0] asid;
    logic [DEF_PPN_WIDTH-1:0]  ppn;
    logic                      writable;
    logic                      valid;
  } tlb_entry_t;

  // Index width for n entries; a single-entry array still needs one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tlb_victim_sel.sv
// tlb_victim_sel: picks the entry that the next page-table fill overwrites.
//
// The lowest invalid entry is preferred. When every entry is valid, a
// round-robin pointer names the victim, and that pointer only moves on when
// a fill actually consumed it.
//
// Ports:
//   clk, rst    clock and asynchronous active-high reset
//   valid_vec   valid bit of every entry
//   advance     a fill is being written this cycle at victim_idx
//   victim_idx  index the next fill writes
module tlb_victim_sel
  import tlb_pkg::*;
#(
  parameter int NUM_ENTRIES = DEF_NUM_ENTRIES
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_ENTRIES-1:0]              valid_vec,
  input  logic                                advance,
  output logic [idx_width(NUM_ENTRIES)-1:0]   victim_idx
);

  localparam int IDX_WIDTH = idx_width(NUM_ENTRIES);

  logic [IDX_WIDTH-1:0] rr_ptr;
  logic [IDX_WIDTH-1:0] free_idx;
  logic                 free_found;

  // Find-first-invalid: walking downwards leaves the lowest free index.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_vec[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_WIDTH'(i);
      end
    end
  end

  assign victim_idx = free_found ? free_idx : rr_ptr;

  // The pointer wraps naturally because NUM_ENTRIES is a power of two.
  // Fills that land in a free slot leave it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (advance && !free_found) begin
      rr_ptr <= rr_ptr + IDX_WIDTH'(1);
    end
  end

endmodule

// File: rtl/asid_tlb.sv
// asid_tlb: fully associative, ASID-tagged translation buffer for one stage
// port, with write-permission checking and a request/response handshake to
// the shared page-table walker.
//
// Optional feature: define TLB_PERF_CNT_EN to build the hit/miss counters;
// without it perf_hits/perf_misses are tied to 0.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   lookup_valid, va_in,        translation request (va_in held while stall)
//   asid_in, is_store, admin    ASID, store access, bypass mode
//   ppn_out, hit, stall, fault  translation result to the stage
//   ptw_req, ptw_va, ptw_asid   walk request (held until response)
//   ptw_valid, ptw_ppn,         walk response
//   ptw_writable, ptw_fault
//   flush_all, flush_asid,      invalidation controls
//   flush_asid_val
//   perf_hits, perf_misses      performance counters
module asid_tlb
  import tlb_pkg::*;
#(
  parameter int VA_WIDTH          = DEF_VA_WIDTH,
  parameter int PAGE_OFFSET_WIDTH = DEF_PAGE_OFFSET_WIDTH,
  parameter int PPN_WIDTH         = DEF_PPN_WIDTH,
  parameter int NUM_ENTRIES       = DEF_NUM_ENTRIES,
  parameter int ASID_WIDTH        = DEF_ASID_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lookup_valid,
  input  logic [VA_WIDTH-1:0]   va_in,
  input  logic [ASID_WIDTH-1:0] asid_in,
  input  logic                  is_store,
  input  logic                  admin,
  output logic [PPN_WIDTH-1:0]  ppn_out,
  output logic                  hit,
  output logic                  stall,
  output logic                  fault,
  output logic                  ptw_req,
  output logic [VA_WIDTH-1:0]   ptw_va,
  output logic [ASID_WIDTH-1:0] ptw_asid,
  input  logic                  ptw_valid,
  input  logic [PPN_WIDTH-1:0]  ptw_ppn,
  input  logic                  ptw_writable,
  input  logic                  ptw_fault,
  input  logic                  flush_all,
  input  logic                  flush_asid,
  input  logic [ASID_WIDTH-1:0] flush_asid_val,
  output logic [31:0]           perf_hits,
  output logic [31:0]           perf_misses
);

  localparam int VPN_WIDTH = VA_WIDTH - PAGE_OFFSET_WIDTH;
  localparam int IDX_WIDTH = idx_width(NUM_ENTRIES);

  // Same layout as tlb_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [VPN_WIDTH-1:0]  vpn;
    logic [ASID_WIDTH-1:0] asid;
    logic [PPN_WIDTH-1:0]  ppn;
    logic                  writable;
    logic                  valid;
  } entry_t;

  entry_t entries      [NUM_ENTRIES];
  entry_t entries_next [NUM_ENTRIES];

  tlb_state_e state, state_next;

  logic [VA_WIDTH-1:0]   walk_va;
  logic [ASID_WIDTH-1:0] walk_asid;
  logic                  kill_q;
  logic                  walk_fault_q;

  logic [VPN_WIDTH-1:0]   req_vpn;
  logic                   match_found;
  logic [IDX_WIDTH-1:0]   match_idx;
  logic [NUM_ENTRIES-1:0] valid_vec;
  logic [IDX_WIDTH-1:0]   victim_idx;

  logic perm_fault;
  logic start_walk;
  logic fill;

  assign req_vpn = va_in[VA_WIDTH-1:PAGE_OFFSET_WIDTH];

  // Associative match across all entries; descending scan so the lowest
  // matching index is the one reported.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (entries[i].valid && entries[i].vpn == req_vpn && entries[i].asid == asid_in) begin
        match_found = 1'b1;
        match_idx   = IDX_WIDTH'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      valid_vec[i] = entries[i].valid;
    end
  end

  tlb_victim_sel #(
    .NUM_ENTRIES (NUM_ENTRIES)
  ) u_victim_sel (
    .clk        (clk),
    .rst        (rst),
    .valid_vec  (valid_vec),
    .advance    (fill),
    .victim_idx (victim_idx)
  );

  // Next-state and stage-facing outputs. In the cycle that carries a
  // registered walk-fault pulse the lookup is held off, so the stage sees
  // only the fault and no fresh walk is launched for the same request.
  always_comb begin
    state_next = state;
    hit        = 1'b0;
    stall      = 1'b0;
    perm_fault = 1'b0;
    ppn_out    = '0;
    start_walk = 1'b0;
    fill       = 1'b0;
    case (state)
      IDLE: begin
        if (admin) begin
          ppn_out = va_in[PPN_WIDTH-1:0];
          hit     = lookup_valid;
        end else if (walk_fault_q) begin
          hit = 1'b0;
        end else if (lookup_valid) begin
          if (match_found) begin
            if (!is_store || entries[match_idx].writable) begin
              hit     = 1'b1;
              ppn_out = entries[match_idx].ppn;
            end else begin
              perm_fault = 1'b1;
            end
          end else begin
            stall      = 1'b1;
            start_walk = 1'b1;
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (ptw_valid) begin
          fill       = !ptw_fault && !kill_q;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign fault    = perm_fault | walk_fault_q;
  assign ptw_req  = (state == WAIT);
  assign ptw_va   = walk_va;
  assign ptw_asid = walk_asid;

  // FSM register plus the walk context. A flush seen while waiting marks the
  // walk as stale so its response is swallowed; a walk fault becomes a
  // one-cycle pulse in the IDLE cycle that follows the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      walk_va      <= '0;
      walk_asid    <= '0;
      kill_q       <= 1'b0;
      walk_fault_q <= 1'b0;
    end else begin
      state        <= state_next;
      walk_fault_q <= (state == WAIT) && ptw_valid && ptw_fault && !kill_q;
      if (start_walk) begin
        walk_va   <= va_in;
        walk_asid <= asid_in;
        kill_q    <= 1'b0;
      end else if (state == WAIT) begin
        if (ptw_valid) begin
          kill_q <= 1'b0;
        end else if (flush_all || flush_asid) begin
          kill_q <= 1'b1;
        end
      end
    end
  end

  // Entry update: the fill lands first and the flush is applied on top, so
  // a fill that coincides with a matching flush is left invalid.
  always_comb begin
    entries_next = entries;
    if (fill) begin
      entries_next[victim_idx].vpn      = walk_va[VA_WIDTH-1:PAGE_OFFSET_WIDTH];
      entries_next[victim_idx].asid     = walk_asid;
      entries_next[victim_idx].ppn      = ptw_ppn;
      entries_next[victim_idx].writable = ptw_writable;
      entries_next[victim_idx].valid    = 1'b1;
    end
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (flush_all || (flush_asid && entries_next[i].asid == flush_asid_val)) begin
        entries_next[i].valid = 1'b0;
      end
    end
  end

  // Entry storage; reset clears every field so valid bits start at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        entries[i] <= '0;
      end
    end else begin
      entries <= entries_next;
    end
  end

`ifdef TLB_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
  logic        hit_event;

  // hit is only raised in IDLE; excluding admin leaves genuine lookups.
  assign hit_event = hit && !admin;

  // Free-running wrap-around counters of lookup hits and walk launches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit_event) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if (start_walk) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end

  assign perf_hits   = hit_cnt;
  assign perf_misses = miss_cnt;
`else
  assign perf_hits   = '0;
  assign perf_misses = '0;
`endif

endmodule

// File: tb/tb_asid_tlb.sv
// tb_asid_tlb: self-checking bench for asid_tlb. Directed scenarios followed
// by randomized traffic, all predicted by a table-level model of the TLB.
module tb_asid_tlb;

  localparam int N = 16;

  logic        clk;
  logic        rst;
  logic        lookup_valid;
  logic [31:0] va_in;
  logic [7:0]  asid_in;
  logic        is_store;
  logic        admin;
  logic [19:0] ppn_out;
  logic        hit;
  logic        stall;
  logic        fault;
  logic        ptw_req;
  logic [31:0] ptw_va;
  logic [7:0]  ptw_asid;
  logic        ptw_valid;
  logic [19:0] ptw_ppn;
  logic        ptw_writable;
  logic        ptw_fault;
  logic        flush_all;
  logic        flush_asid;
  logic [7:0]  flush_asid_val;
  logic [31:0] perf_hits;
  logic [31:0] perf_misses;

  asid_tlb dut (
    .clk            (clk),
    .rst            (rst),
    .lookup_valid   (lookup_valid),
    .va_in          (va_in),
    .asid_in        (asid_in),
    .is_store       (is_store),
    .admin          (admin),
    .ppn_out        (ppn_out),
    .hit            (hit),
    .stall          (stall),
    .fault          (fault),
    .ptw_req        (ptw_req),
    .ptw_va         (ptw_va),
    .ptw_asid       (ptw_asid),
    .ptw_valid      (ptw_valid),
    .ptw_ppn        (ptw_ppn),
    .ptw_writable   (ptw_writable),
    .ptw_fault      (ptw_fault),
    .flush_all      (flush_all),
    .flush_asid     (flush_asid),
    .flush_asid_val (flush_asid_val),
    .perf_hits      (perf_hits),
    .perf_misses    (perf_misses)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Reference table: a list of translations with a replacement cursor.
  bit          m_valid [N];
  logic [19:0] m_vpn   [N];
  logic [7:0]  m_asid  [N];
  logic [19:0] m_ppn   [N];
  bit          m_wr    [N];
  int          m_ptr;
  int          exp_hits;
  int          exp_misses;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic int modelFind(input logic [19:0] vpn, input logic [7:0] asid);
    for (int i = 0; i < N; i++) begin
      if (m_valid[i] && m_vpn[i] == vpn && m_asid[i] == asid) return i;
    end
    return -1;
  endfunction

  function automatic void modelFill(input logic [19:0] vpn, input logic [7:0] asid, input logic [19:0] ppn, input bit wr);
    int v;
    v = -1;
    for (int i = 0; i < N; i++) begin
      if (!m_valid[i] && v < 0) v = i;
    end
    if (v < 0) begin
      v = m_ptr;
      m_ptr = (m_ptr + 1) % N;
    end
    m_valid[v] = 1'b1;
    m_vpn[v]   = vpn;
    m_asid[v]  = asid;
    m_ppn[v]   = ppn;
    m_wr[v]    = wr;
  endfunction

  function automatic void modelFlush(input bit all, input logic [7:0] asid);
    for (int i = 0; i < N; i++) begin
      if (all || m_asid[i] == asid) m_valid[i] = 1'b0;
    end
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    m_ptr = 0;
    exp_hits = 0;
    exp_misses = 0;
  endfunction

  // One complete request: lookup, any walk(s) with the given response, and
  // the final outcome. Inputs change at posedge+1, outputs are sampled at
  // the falling edge.
  task automatic applyStimulus(input logic [31:0] va, input logic [7:0] asid, input bit store,
                               input int delay_in, input logic [19:0] rppn, input bit rwr,
                               input bit rfault, input bit kill);
    int  idx;
    int  walks;
    int  delay;
    bit  done;
    bit  killed;
    done  = 1'b0;
    walks = 0;
    delay = (kill && delay_in == 0) ? 1 : delay_in;
    lookup_valid = 1'b1;
    va_in        = va;
    asid_in      = asid;
    is_store     = store;
    admin        = 1'b0;
    while (!done && walks < 4) begin
      @(negedge clk);
      idx = modelFind(va[31:12], asid);
      if (idx >= 0 && (!store || m_wr[idx])) begin
        checkOutput("hit", hit, 1);
        checkOutput("hit_ppn", ppn_out, m_ppn[idx]);
        checkOutput("hit_stall", stall, 0);
        checkOutput("hit_fault", fault, 0);
        exp_hits++;
        @(posedge clk); #1;
        done = 1'b1;
      end else if (idx >= 0) begin
        checkOutput("perm_fault", fault, 1);
        checkOutput("perm_hit", hit, 0);
        checkOutput("perm_stall", stall, 0);
        @(posedge clk); #1;
        lookup_valid = 1'b0;
        @(negedge clk);
        checkOutput("perm_no_walk", ptw_req, 0);
        checkOutput("perm_pulse_len", fault, 0);
        @(posedge clk); #1;
        done = 1'b1;
      end else begin
        checkOutput("miss_stall", stall, 1);
        checkOutput("miss_hit", hit, 0);
        checkOutput("miss_fault", fault, 0);
        exp_misses++;
        @(posedge clk); #1;
        walks++;
        killed = 1'b0;
        if (kill && walks == 1) flush_all = 1'b1;
        for (int k = 0; k < delay; k++) begin
          @(negedge clk);
          checkOutput("wait_req", ptw_req, 1);
          checkOutput("wait_stall", stall, 1);
          checkOutput("wait_va", ptw_va, va);
          checkOutput("wait_asid", ptw_asid, asid);
          @(posedge clk); #1;
          if (flush_all) begin
            flush_all = 1'b0;
            modelFlush(1'b1, 8'h00);
            killed = 1'b1;
          end
        end
        ptw_valid    = 1'b1;
        ptw_ppn      = rppn;
        ptw_writable = rwr;
        ptw_fault    = rfault;
        @(negedge clk);
        checkOutput("resp_req", ptw_req, 1);
        checkOutput("resp_va", ptw_va, va);
        @(posedge clk); #1;
        ptw_valid    = 1'b0;
        ptw_ppn      = 20'($urandom);
        ptw_fault    = 1'b0;
        if (killed) begin
          // Stale response: the loop re-evaluates and expects another miss.
        end else if (rfault) begin
          @(negedge clk);
          checkOutput("walk_fault", fault, 1);
          checkOutput("walk_fault_hit", hit, 0);
          checkOutput("walk_fault_stall", stall, 0);
          @(posedge clk); #1;
          lookup_valid = 1'b0;
          @(negedge clk);
          checkOutput("walk_fault_len", fault, 0);
          checkOutput("walk_fault_req", ptw_req, 0);
          @(posedge clk); #1;
          done = 1'b1;
        end else begin
          modelFill(va[31:12], asid, rppn, rwr);
        end
      end
    end
    if (!done) checkOutput("txn_bound", 0, 1);
    lookup_valid = 1'b0;
  endtask

  task automatic applyAdmin(input logic [31:0] va);
    lookup_valid = 1'b1;
    admin        = 1'b1;
    va_in        = va;
    is_store     = 1'($urandom);
    @(negedge clk);
    checkOutput("admin_hit", hit, 1);
    checkOutput("admin_ppn", ppn_out, va[19:0]);
    checkOutput("admin_stall", stall, 0);
    @(posedge clk); #1;
    admin        = 1'b0;
    lookup_valid = 1'b0;
    @(negedge clk);
    checkOutput("admin_no_walk", ptw_req, 0);
    @(posedge clk); #1;
  endtask

  task automatic applyFlush(input bit all, input logic [7:0] asid);
    flush_all      = all;
    flush_asid     = !all;
    flush_asid_val = asid;
    @(posedge clk); #1;
    flush_all  = 1'b0;
    flush_asid = 1'b0;
    modelFlush(all, asid);
  endtask

  // Idle cycles, optionally with a stray walker strobe that must be ignored.
  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      ptw_valid = ($urandom_range(0, 3) == 0);
      ptw_fault = 1'($urandom);
      @(posedge clk); #1;
      ptw_valid = 1'b0;
      ptw_fault = 1'b0;
    end
  endtask

  task automatic checkPerf();
`ifdef TLB_PERF_CNT_EN
    checkOutput("perf_hits", perf_hits, exp_hits);
    checkOutput("perf_misses", perf_misses, exp_misses);
`else
    checkOutput("perf_hits", perf_hits, 0);
    checkOutput("perf_misses", perf_misses, 0);
`endif
  endtask

  initial begin
    logic [31:0] va;
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    lookup_valid = 1'b0;
    va_in = '0;
    asid_in = '0;
    is_store = 1'b0;
    admin = 1'b0;
    ptw_valid = 1'b0;
    ptw_ppn = '0;
    ptw_writable = 1'b0;
    ptw_fault = 1'b0;
    flush_all = 1'b0;
    flush_asid = 1'b0;
    flush_asid_val = '0;
    modelReset();

    #12;
    checkOutput("rst_hit", hit, 0);
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_fault", fault, 0);
    checkOutput("rst_req", ptw_req, 0);
    checkOutput("rst_ppn", ppn_out, 0);
    checkOutput("rst_ptw_va", ptw_va, 0);
    checkOutput("rst_ptw_asid", ptw_asid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    checkPerf();

    $display("[TB] cold miss and ASID isolation");
    applyStimulus(32'h0001_2345, 8'd3, 1'b0, 4, 20'hABCDE, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h0001_2345, 8'd3, 1'b0, 0, 20'h00000, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h0001_2345, 8'd4, 1'b0, 2, 20'h11111, 1'b1, 1'b0, 1'b0);
    applyFlush(1'b0, 8'd3);
    applyStimulus(32'h0001_2345, 8'd3, 1'b0, 1, 20'h22222, 1'b1, 1'b1, 1'b0);
    applyStimulus(32'h0001_2FFF, 8'd4, 1'b0, 1, 20'h22222, 1'b1, 1'b0, 1'b0);

    $display("[TB] permission and walk faults");
    applyStimulus(32'h0004_0010, 8'd3, 1'b1, 3, 20'h33333, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h0004_0020, 8'd3, 1'b0, 1, 20'h00000, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h0005_0000, 8'd3, 1'b0, 2, 20'h55555, 1'b1, 1'b1, 1'b0);
    applyStimulus(32'h0005_0000, 8'd3, 1'b0, 0, 20'h55555, 1'b1, 1'b1, 1'b0);

    $display("[TB] replacement");
    applyFlush(1'b1, 8'd0);
    for (int i = 0; i < N; i++) begin
      applyStimulus({20'h00100 + 20'(i), 12'h000}, 8'd1, 1'b0, 0, 20'h80000 + 20'(i), 1'b1, 1'b0, 1'b0);
    end
    applyStimulus(32'h0020_0000, 8'd1, 1'b0, 1, 20'h90000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) begin
      applyStimulus({20'h00100 + 20'(i), 12'h000}, 8'd1, 1'b0, 0, 20'h0, 1'b1, 1'b1, 1'b0);
    end
    applyStimulus(32'h0020_1000, 8'd1, 1'b0, 1, 20'h90001, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h0010_1000, 8'd1, 1'b0, 0, 20'h0, 1'b1, 1'b1, 1'b0);
    applyStimulus(32'h0010_2000, 8'd1, 1'b0, 0, 20'h0, 1'b1, 1'b1, 1'b0);
    applyFlush(1'b1, 8'd0);
    applyStimulus(32'h0010_3000, 8'd1, 1'b0, 0, 20'h0, 1'b1, 1'b1, 1'b0);
    applyStimulus(32'h0020_0000, 8'd1, 1'b0, 0, 20'h0, 1'b1, 1'b1, 1'b0);

    $display("[TB] flush during walk");
    applyStimulus(32'h0007_0000, 8'd2, 1'b0, 3, 20'h44444, 1'b1, 1'b0, 1'b1);
    applyStimulus(32'h0007_0004, 8'd2, 1'b0, 0, 20'h0, 1'b1, 1'b0, 1'b0);
    checkPerf();
    applyAdmin($urandom);

    $display("[TB] randomized traffic");
    for (int t = 0; t < 250; t++) begin
      int sel;
      sel = $urandom_range(0, 19);
      if (sel == 0) begin
        applyFlush(1'b1, 8'd0);
      end else if (sel <= 2) begin
        applyFlush(1'b0, 8'($urandom_range(1, 3)));
      end else if (sel == 3) begin
        applyAdmin($urandom);
      end else begin
        va = {20'h00300 + 20'($urandom_range(0, 23)), 12'($urandom)};
        applyStimulus(va, 8'($urandom_range(1, 3)), ($urandom_range(0, 3) == 0),
                      $urandom_range(0, 5), 20'($urandom), 1'($urandom),
                      ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
      end
      idleCycles($urandom_range(0, 2));
    end
    checkPerf();

    $display("[TB] reset during walk");
    lookup_valid = 1'b1;
    va_in        = 32'h00EE_E000;
    asid_in      = 8'd7;
    is_store     = 1'b0;
    @(negedge clk);
    checkOutput("rst_walk_stall", stall, (modelFind(20'h00EEE, 8'd7) < 0) ? 1 : 0);
    @(posedge clk); #1;
    exp_misses++;
    @(negedge clk);
    checkOutput("rst_walk_req", ptw_req, 1);
    checkPerf();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_walk_drop", ptw_req, 0);
    modelReset();
    lookup_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    checkPerf();
    applyStimulus(32'h0001_2345, 8'd4, 1'b0, 1, 20'h12121, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h00EE_E000, 8'd7, 1'b0, 2, 20'h34343, 1'b0, 1'b0, 1'b0);
    checkPerf();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
